// File: rtl/alu_operand_stage_pkg.sv
// Shared types and constants for the ALU operand (ID/EX) stage.
// Holds opcodes, widths, REG_ZERO and the id_ex_t entry bundle.
package alu_operand_stage_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_LSR  = 4'd8,
    ALU_ASR  = 4'd9
  } alu_op_e;

  typedef struct packed {
    alu_op_e           op;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic              sel_0;
    logic              sel_1;
    logic [REG_AW-1:0] rd;
    logic              we;
  } id_ex_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Upstream/downstream valid-ready bundle of the ALU operand stage.
// slave = the stage itself, master = the driver around it.
interface alu_operand_stage_if;
  import alu_operand_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  alu_op_e           in_op;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [XLEN-1:0]   in_rs1_data;
  logic [XLEN-1:0]   in_rs2_data;
  logic [XLEN-1:0]   in_imm;
  logic [XLEN-1:0]   in_pc;
  logic              in_sel_0;
  logic              in_sel_1;
  logic [REG_AW-1:0] in_rd;
  logic              in_we;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_in_0;
  logic [XLEN-1:0]   out_in_1;
  alu_op_e           out_op;
  logic [XLEN-1:0]   out_rs2_data;
  logic [REG_AW-1:0] out_rd;
  logic              out_we;

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2,
    input  in_rs1_data, in_rs2_data, in_imm, in_pc,
    input  in_sel_0, in_sel_1, in_rd, in_we,
    input  out_ready,
    output in_ready,
    output out_valid, out_in_0, out_in_1, out_op,
    output out_rs2_data, out_rd, out_we
  );

  modport master (
    output in_valid, in_op, in_rs1, in_rs2,
    output in_rs1_data, in_rs2_data, in_imm, in_pc,
    output in_sel_0, in_sel_1, in_rd, in_we,
    output out_ready,
    input  in_ready,
    input  out_valid, out_in_0, out_in_1, out_op,
    input  out_rs2_data, out_rd, out_we
  );

endinterface

// File: rtl/alu_operand_stage_fwd_select.sv
// Per-source operand select: x0 > EX forward > WB forward > stored.
// ALU_STAGE_FWD_EN enables EX forwarding; otherwise any EX match stalls.
module alu_operand_stage_fwd_select
  import alu_operand_stage_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic [XLEN-1:0]   data,
  input  logic              ex_we,
  input  logic              ex_pending,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   value,
  output logic              wb_hit,
  output logic              hazard
);

  logic nz;
  logic ex_hit;

  assign nz     = rs != REG_ZERO;
  assign ex_hit = ex_we && (ex_rd == rs) && nz;
  assign wb_hit = wb_we && (wb_rd == rs) && nz;

`ifdef ALU_STAGE_FWD_EN
  // Youngest producer wins; x0 is hardwired to zero.
  always_comb begin
    value = data;
    priority case (1'b1)
      !nz:     value = '0;
      ex_hit:  value = ex_data;
      wb_hit:  value = wb_data;
      default: value = data;
    endcase
  end

  assign hazard = ex_hit && ex_pending;
`else
  // No EX path: WB or stored data only; EX producer must retire first.
  always_comb begin
    value = data;
    priority case (1'b1)
      !nz:     value = '0;
      wb_hit:  value = wb_data;
      default: value = data;
    endcase
  end

  assign hazard = ex_hit;

  logic unused_ex;
  assign unused_ex = ^{ex_pending, ex_data};
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// Single-entry ID/EX stage feeding the ALU, with forwarding and stall.
// Build option: define ALU_STAGE_FWD_EN to enable EX/MEM forwarding.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ex_we,
  input  logic              ex_pending,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  alu_operand_stage_if.slave bus
);

  logic   full;
  id_ex_t entry;
  id_ex_t in_entry;
  logic   pop;
  logic   push;
  logic   hazard;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            wb_hit_1;
  logic            wb_hit_2;
  logic            haz_1;
  logic            haz_2;

  assign in_entry = '{
    op:       bus.in_op,
    rs1:      bus.in_rs1,
    rs2:      bus.in_rs2,
    rs1_data: bus.in_rs1_data,
    rs2_data: bus.in_rs2_data,
    imm:      bus.in_imm,
    pc:       bus.in_pc,
    sel_0:    bus.in_sel_0,
    sel_1:    bus.in_sel_1,
    rd:       bus.in_rd,
    we:       bus.in_we
  };

  alu_operand_stage_fwd_select u_fwd_rs1 (
    .rs         (entry.rs1),
    .data       (entry.rs1_data),
    .ex_we      (ex_we),
    .ex_pending (ex_pending),
    .ex_rd      (ex_rd),
    .ex_data    (ex_data),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .value      (rs1_val),
    .wb_hit     (wb_hit_1),
    .hazard     (haz_1)
  );

  alu_operand_stage_fwd_select u_fwd_rs2 (
    .rs         (entry.rs2),
    .data       (entry.rs2_data),
    .ex_we      (ex_we),
    .ex_pending (ex_pending),
    .ex_rd      (ex_rd),
    .ex_data    (ex_data),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .value      (rs2_val),
    .wb_hit     (wb_hit_2),
    .hazard     (haz_2)
  );

  // rs1 is ignored when the PC is selected; rs2 may be store data.
  assign hazard = (haz_1 && !entry.sel_0) || haz_2;

  assign bus.out_valid = full && !hazard;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.in_ready  = !full || pop;
  assign push          = bus.in_valid && bus.in_ready && !flush;

  assign bus.out_in_0     = entry.sel_0 ? entry.pc  : rs1_val;
  assign bus.out_in_1     = entry.sel_1 ? entry.imm : rs2_val;
  assign bus.out_rs2_data = rs2_val;
  assign bus.out_op       = entry.op;
  assign bus.out_rd       = entry.rd;
  assign bus.out_we       = entry.we;

  // Occupancy: flush beats push, push beats pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  // Entry capture, then WB snoop while the entry waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry    <= '0;
      entry.op <= ALU_ADD;
    end else if (push) begin
      entry <= in_entry;
    end else if (full && !pop) begin
      if (wb_hit_1) entry.rs1_data <= wb_data;
      if (wb_hit_2) entry.rs2_data <= wb_data;
    end
  end

endmodule
